hsl_frame_sequencer: RTL and testbench

- Frame-level controller for the RGB-to-HSL converter datapath.
- Reads NPIX pixels from the RGB source memory and drives the converter's valid_in with matching timing.
- Tracks in-flight pixels through the converter's fixed-latency pipeline and generates write strobes and addresses for the HSL result memory.
- Reports busy/done to the top-level control.

---
 rtl/hsl_frame_sequencer_if.sv | 39 +++
 rtl/hsl_frame_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hsl_frame_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hsl_frame_sequencer_if.sv
// Control and memory-strobe bundle between the top-level controller and the
// HSL frame sequencer.
interface hsl_frame_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              hold;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              conv_valid_in;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output hold,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  conv_valid_in,
        input  res_wr_en,
        input  res_wr_addr,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hold,
        output mem_rd_en,
        output mem_rd_addr,
        output conv_valid_in,
        output res_wr_en,
        output res_wr_addr,
        output busy,
        output done
    );
endinterface

// File: rtl/hsl_frame_sequencer.sv
// Frame sequencer for the RGB-to-HSL datapath: issues source reads, tracks
// pixels through the memory and converter latencies, and strobes result writes.
module hsl_frame_sequencer #(
    parameter int NPIX     = 25000,
    parameter int ADDR_W   = 15,
    parameter int MEM_LAT  = 1,
    parameter int CONV_LAT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    hsl_frame_sequencer_if.slave  io_bus
);

    // One extra counter bit so the compare against NPIX cannot wrap when NPIX == 2**ADDR_W.
    localparam int                CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  C_NPIX      = CNT_W'(NPIX);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NPIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic [ADDR_W-1:0]   r_res_wr_addr;
    logic                r_busy;
    logic                r_done;
    logic [MEM_LAT-1:0]  r_mem_sr;
    logic [MEM_LAT-1:0]  w_mem_sr_nxt;
    logic [CONV_LAT-1:0] r_conv_sr;
    logic [CONV_LAT-1:0] w_conv_sr_nxt;
    logic                w_start_frame;
    logic                w_issue;
    logic                w_conv_valid;
    logic                w_res_wr_en;

    assign w_conv_valid  = r_mem_sr[MEM_LAT-1];
    assign w_res_wr_en   = r_conv_sr[CONV_LAT-1];
    assign w_start_frame = (r_state == S_IDLE) && io_bus.start;
    assign w_issue       = (r_state == S_RUN) && !io_bus.hold && (r_issue_cnt < C_NPIX);

    // Delay lines: a single-stage line has no older bits to shift along.
    if (MEM_LAT == 1) begin : g_mem_sr_one
        assign w_mem_sr_nxt = r_mem_rd_en;
    end else begin : g_mem_sr_many
        assign w_mem_sr_nxt = {r_mem_sr[MEM_LAT-2:0], r_mem_rd_en};
    end

    if (CONV_LAT == 1) begin : g_conv_sr_one
        assign w_conv_sr_nxt = w_conv_valid;
    end else begin : g_conv_sr_many
        assign w_conv_sr_nxt = {r_conv_sr[CONV_LAT-2:0], w_conv_valid};
    end

    // Next-state decode for the frame controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_issue_cnt == C_NPIX) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (r_wr_cnt == C_NPIX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, status flags and the read-issue side of the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= {ADDR_W{1'b0}};
            r_issue_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE);
            r_mem_rd_en <= w_issue;
            if (w_start_frame) begin
                r_issue_cnt <= {CNT_W{1'b0}};
            end else if (w_issue) begin
                r_issue_cnt   <= r_issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_mem_rd_addr <= r_issue_cnt[ADDR_W-1:0];
            end else begin
                r_issue_cnt   <= r_issue_cnt;
                r_mem_rd_addr <= r_mem_rd_addr;
            end
        end
    end

    // Valid delay lines through memory and converter; hold gaps ride along unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_sr  <= {MEM_LAT{1'b0}};
            r_conv_sr <= {CONV_LAT{1'b0}};
        end else begin
            r_mem_sr  <= w_mem_sr_nxt;
            r_conv_sr <= w_conv_sr_nxt;
        end
    end

    // Result-write bookkeeping; the address stops at the last pixel instead of running past it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt      <= {CNT_W{1'b0}};
            r_res_wr_addr <= {ADDR_W{1'b0}};
        end else if (w_start_frame) begin
            r_wr_cnt      <= {CNT_W{1'b0}};
            r_res_wr_addr <= {ADDR_W{1'b0}};
        end else if (w_res_wr_en) begin
            if (r_wr_cnt < C_NPIX) begin
                r_wr_cnt <= r_wr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_wr_cnt <= r_wr_cnt;
            end
            if (r_res_wr_addr != C_LAST_ADDR) begin
                r_res_wr_addr <= r_res_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                r_res_wr_addr <= r_res_wr_addr;
            end
        end else begin
            r_wr_cnt      <= r_wr_cnt;
            r_res_wr_addr <= r_res_wr_addr;
        end
    end

    assign io_bus.mem_rd_en     = r_mem_rd_en;
    assign io_bus.mem_rd_addr   = r_mem_rd_addr;
    assign io_bus.conv_valid_in = w_conv_valid;
    assign io_bus.res_wr_en     = w_res_wr_en;
    assign io_bus.res_wr_addr   = r_res_wr_addr;
    assign io_bus.busy          = r_busy;
    assign io_bus.done          = r_done;

endmodule

// File: tb/tb_hsl_frame_sequencer.sv
// Directed bench for hsl_frame_sequencer: per-cycle expected-output tables for
// whole frames plus hand sequences for restart attempts and mid-frame reset.
module tb_hsl_frame_sequencer;

    localparam int NPIX     = 8;
    localparam int ADDR_W   = 3;
    localparam int MEM_LAT  = 1;
    localparam int CONV_LAT = 10;

    logic clk;
    logic rst;

    hsl_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    hsl_frame_sequencer #(
        .NPIX     (NPIX),
        .ADDR_W   (ADDR_W),
        .MEM_LAT  (MEM_LAT),
        .CONV_LAT (CONV_LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {mem_rd_en, mem_rd_addr[2:0], conv_valid_in, res_wr_en, res_wr_addr[2:0], busy, done}
    typedef struct {
        logic        start;
        logic        hold;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [10:0] outs();
        return {bus.mem_rd_en, bus.mem_rd_addr, bus.conv_valid_in, bus.res_wr_en,
                bus.res_wr_addr, bus.busy, bus.done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Frame table, cycle 0 = cycle start is driven. First read lands in cycle 2; reads
    // at index >= gap_at are pushed back gap_len cycles by hold. conv = read+1,
    // write = read+11, done = first read + 20 + gap_len.
    task automatic build_frame(input int gap_at, input int gap_len, input logic [2:0] prior_rd,
                               input logic [2:0] prior_wr, input bit start_on_done);
        int   read_cyc[8];
        int   done_cyc;
        int   last_c;
        int   nwr;
        vec_t v;
        logic rd_en, cv, we, busy_e, done_e;
        logic [2:0] rd_addr, wa;
        tbl.delete();
        for (int r = 0; r < 8; r++) read_cyc[r] = 2 + r + ((r >= gap_at) ? gap_len : 0);
        done_cyc = read_cyc[0] + 20 + gap_len;
        last_c   = start_on_done ? done_cyc : done_cyc + 1;
        for (int c = 0; c <= last_c; c++) begin
            v.start = (c == 0) || (start_on_done && c == done_cyc);
            v.hold  = (gap_len > 0) && (c >= read_cyc[0] + gap_at - 1) &&
                      (c < read_cyc[0] + gap_at - 1 + gap_len);
            rd_en = 1'b0; cv = 1'b0; we = 1'b0; rd_addr = prior_rd; nwr = 0;
            for (int r = 0; r < 8; r++) begin
                if (read_cyc[r] == c) rd_en = 1'b1;
                if (read_cyc[r] <= c) rd_addr = 3'(r);
                if (read_cyc[r] + 1 == c) cv = 1'b1;
                if (read_cyc[r] + 11 == c) we = 1'b1;
                if (read_cyc[r] + 11 < c) nwr++;
            end
            wa     = (c == 0) ? prior_wr : ((nwr > 7) ? 3'd7 : 3'(nwr));
            busy_e = (c >= 1) && (c < done_cyc);
            done_e = (c == done_cyc);
            v.exp  = {rd_en, rd_addr, cv, we, wa, busy_e, done_e};
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            bus.start = tbl[i].start;
            bus.hold  = tbl[i].hold;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), 32'(outs()), 32'(tbl[i].exp));
        end
    endtask

    initial begin
        int nwr;
        int ndone;
        int done_at;
        int stray;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'd0);

        // Back-to-back: start in the DONE cycle is ignored, start the cycle after restarts.
        build_frame(8, 0, 3'd0, 3'd0, 1'b1);
        run_table("basic");
        build_frame(8, 0, 3'd7, 3'd7, 1'b0);
        run_table("b2b");

        build_frame(4, 3, 3'd7, 3'd7, 1'b0);
        run_table("hold_gap");

        // Start during RUN and DRAIN, hold during DRAIN: no effect on the frame.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.hold  = 1'b0;
        nwr = 0; ndone = 0; done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            bus.start = (c == 4) || (c == 15);
            bus.hold  = (c >= 14) && (c <= 16);
            @(negedge clk);
            if (bus.res_wr_en) begin
                check($sformatf("busy_start_wr_addr%0d", nwr), 32'(bus.res_wr_addr), 32'(nwr));
                nwr++;
            end
            if (bus.done) begin
                ndone++;
                done_at = c;
            end
        end
        check("busy_start_writes", 32'(nwr), 32'd8);
        check("busy_start_dones", 32'(ndone), 32'd1);
        check("busy_start_done_cycle", 32'(done_at), 32'd22);

        // Mid-frame reset after five reads, then a clean frame from address 0.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.hold  = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        #2;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("reset_async_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.res_wr_en || bus.busy || bus.mem_rd_en || bus.conv_valid_in) stray++;
        end
        check("post_reset_quiet", 32'(stray), 32'd0);
        build_frame(8, 0, 3'd0, 3'd0, 1'b0);
        run_table("after_reset");

        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
